// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/up/down buttons edit the hour, then the
// minute, and a one-cycle load strobe hands the new time to the time counter.

module time_set_btn #(
    parameter int DEB_CYCLES   = 50000,
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_event
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_level_d;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_press;
    logic             w_rpt_fire;

    assign w_press    = r_level & ~r_level_d;
    assign w_rpt_fire = REPEAT_EN && r_level && (r_rpt_cnt == RPT_LAST);
    assign o_event    = w_press | w_rpt_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_deb_cnt <= '0;
            r_rpt_cnt <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples the pre-edge values.
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;

            if (r_sync[1] == r_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_level   <= r_sync[1];
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end

            // Counts cycles since the press; reloading keeps later repeats REPEAT_RATE apart.
            if (!REPEAT_EN || !r_level) begin
                r_rpt_cnt <= '0;
            end else if (w_rpt_fire) begin
                r_rpt_cnt <= RPT_RELOAD;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
            end
        end
    end
endmodule

module time_set_ctrl #(
    parameter int DEB_CYCLES     = 50000,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_RATE    = 5000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] ora_cur,
    input  logic [5:0] min_cur,
    output logic [4:0] ora_setata,
    output logic [5:0] min_setat,
    output logic       load,
    output logic       run,
    output logic [1:0] edit_field
);
    typedef enum logic [1:0] {S_RUN, S_SET_H, S_SET_M, S_COMMIT} state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            w_mode_ev;
    logic            w_up_ev;
    logic            w_down_ev;
    logic            w_any_ev;
    logic            w_step_up;
    logic            w_step_down;
    logic            w_editing;
    logic            w_timeout;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_ora;
    logic [4:0]      w_ora_nxt;
    logic [5:0]      r_min;
    logic [5:0]      w_min_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_load;
    logic            r_run;
    logic [1:0]      r_edit_field;

    time_set_btn #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b0),
                   .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_btn_mode (.clk(clk), .rst(rst), .i_btn(btn_mode), .o_event(w_mode_ev));
    time_set_btn #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b1),
                   .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_btn_up (.clk(clk), .rst(rst), .i_btn(btn_up), .o_event(w_up_ev));
    time_set_btn #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b1),
                   .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_btn_down (.clk(clk), .rst(rst), .i_btn(btn_down), .o_event(w_down_ev));

    // Mode beats a step; opposing steps cancel each other.
    assign w_any_ev    = w_mode_ev | w_up_ev | w_down_ev;
    assign w_step_up   = w_up_ev & ~w_down_ev & ~w_mode_ev;
    assign w_step_down = w_down_ev & ~w_up_ev & ~w_mode_ev;
    assign w_editing   = (r_state == S_SET_H) || (r_state == S_SET_M);
    assign w_timeout   = w_editing && !w_any_ev && (r_to_cnt == TO_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_ora_nxt   = r_ora;
        w_min_nxt   = r_min;
        case (r_state)
            S_RUN: begin
                if (w_mode_ev) begin
                    w_ora_nxt   = (ora_cur > 5'd23) ? 5'd0 : ora_cur;
                    w_min_nxt   = (min_cur > 6'd59) ? 6'd0 : min_cur;
                    w_state_nxt = S_SET_H;
                end
            end
            S_SET_H: begin
                if (w_mode_ev)        w_state_nxt = S_SET_M;
                else if (w_step_up)   w_ora_nxt = (r_ora == 5'd23) ? 5'd0 : r_ora + 5'd1;
                else if (w_step_down) w_ora_nxt = (r_ora == 5'd0) ? 5'd23 : r_ora - 5'd1;
                else if (w_timeout)   w_state_nxt = S_RUN;
            end
            S_SET_M: begin
                if (w_mode_ev)        w_state_nxt = S_COMMIT;
                else if (w_step_up)   w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                else if (w_step_down) w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
                else if (w_timeout)   w_state_nxt = S_RUN;
            end
            S_COMMIT: w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_ora        <= '0;
            r_min        <= '0;
            r_to_cnt     <= '0;
            r_load       <= 1'b0;
            r_run        <= 1'b1;
            r_edit_field <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_ora    <= w_ora_nxt;
            r_min    <= w_min_nxt;
            r_to_cnt <= (w_editing && !w_any_ev && (w_state_nxt == r_state))
                        ? r_to_cnt + TO_W'(1) : '0;
            // Flags follow the next state so they change on the edge that enters it.
            r_load       <= (w_state_nxt == S_COMMIT);
            r_run        <= !((w_state_nxt == S_SET_H) || (w_state_nxt == S_SET_M));
            r_edit_field <= {w_state_nxt == S_SET_M, w_state_nxt == S_SET_H};
        end
    end

    assign ora_setata = r_ora;
    assign min_setat  = r_min;
    assign load       = r_load;
    assign run        = r_run;
    assign edit_field = r_edit_field;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: stimulus queues the expected output records,
// a monitor compares each observed output change against the queue head.

module tb_time_set_ctrl;
    localparam int DEB  = 4;
    localparam int RDLY = 8;
    localparam int RRATE = 4;
    localparam int TOUT = 64;
    localparam int GAP  = 10;
    localparam logic [2:0] MODE = 3'b100;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] DN   = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [4:0] ora_cur = '0;
    logic [5:0] min_cur = '0;
    logic [4:0] ora_setata;
    logic [5:0] min_setat;
    logic       load;
    logic       run;
    logic [1:0] edit_field;

    typedef struct {
        logic [14:0] val;   // {ora, min, load, run, edit_field}
        int          cyc;   // edge index at which it must appear, -1 = any
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rec_n = 0;
    bit          mon_en = 1'b0;
    logic [14:0] prev;
    logic [14:0] obs;

    time_set_ctrl #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .ora_cur(ora_cur), .min_cur(min_cur), .ora_setata(ora_setata), .min_setat(min_setat),
        .load(load), .run(run), .edit_field(edit_field)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign obs = {ora_setata, min_setat, load, run, edit_field};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic void exp_out(input logic [4:0] o, input logic [5:0] m, input logic ld,
                                    input logic rn, input logic [1:0] ef, input int c = -1);
        exp_t e;
        e.val = {o, m, ld, rn, ef};
        e.cyc = c;
        sb_q.push_back(e);
    endfunction

    task automatic press(input logic [2:0] m, input int hold);
        @(posedge clk);
        #1;
        {btn_mode, btn_up, btn_down} = m;
        repeat (hold) @(posedge clk);
        #1;
        {btn_mode, btn_up, btn_down} = 3'b000;
        repeat (GAP) @(posedge clk);
    endtask

    // Monitor: every change of the output bundle must match the next queued record.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && obs !== prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: actual 0x%0h required no change from 0x%0h",
                             obs, prev);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("record%0d_value", rec_n), {17'b0, obs}, {17'b0, e.val});
                    if (e.cyc >= 0) check($sformatf("record%0d_cycle", rec_n), cyc, e.cyc);
                    rec_n++;
                end
                prev = obs;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ora", ora_setata, 0);
        check("rst_min", min_setat, 0);
        check("rst_load", load, 0);
        check("rst_run", run, 1);
        check("rst_edit_field", edit_field, 0);
        prev   = obs;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Full commit path
        ora_cur = 5'd10; min_cur = 6'd30;
        exp_out(10, 30, 0, 0, 2'b01); press(MODE, 8);
        exp_out(11, 30, 0, 0, 2'b01); press(UP, 8);
        exp_out(12, 30, 0, 0, 2'b01); press(UP, 8);
        exp_out(12, 30, 0, 0, 2'b10); press(MODE, 8);
        exp_out(12, 29, 0, 0, 2'b10); press(DN, 8);
        exp_out(12, 29, 1, 1, 2'b00);
        exp_out(12, 29, 0, 1, 2'b00); press(MODE, 8);

        // Wrap in both fields
        ora_cur = 5'd23; min_cur = 6'd0;
        exp_out(23, 0, 0, 0, 2'b01); press(MODE, 8);
        exp_out(0, 0, 0, 0, 2'b01);  press(UP, 8);
        exp_out(23, 0, 0, 0, 2'b01); press(DN, 8);
        exp_out(23, 0, 0, 0, 2'b10); press(MODE, 8);
        exp_out(23, 59, 0, 0, 2'b10); press(DN, 8);
        exp_out(23, 0, 0, 0, 2'b10); press(UP, 8);
        exp_out(23, 0, 1, 1, 2'b00);
        exp_out(23, 0, 0, 1, 2'b00); press(MODE, 8);

        // Bounce: one increment, DEB+3 edges after the final rising edge
        ora_cur = 5'd5; min_cur = 6'd5;
        exp_out(5, 5, 0, 0, 2'b01); press(MODE, 8);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            btn_up = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        btn_up = 1'b1;
        exp_out(6, 5, 0, 0, 2'b01, cyc + DEB + 3);
        repeat (8) @(posedge clk);
        #1;
        btn_up = 1'b0;
        repeat (GAP) @(posedge clk);

        // Auto-repeat: press + delayed + 2 repeats, minute 5 -> 9
        exp_out(6, 5, 0, 0, 2'b10); press(MODE, 8);
        exp_out(6, 6, 0, 0, 2'b10);
        exp_out(6, 7, 0, 0, 2'b10);
        exp_out(6, 8, 0, 0, 2'b10);
        exp_out(6, 9, 0, 0, 2'b10); press(UP, 20);
        exp_out(6, 9, 1, 1, 2'b00);
        exp_out(6, 9, 0, 1, 2'b00); press(MODE, 8);

        // Timeout: back to RUN after 64 idle cycles, no load
        ora_cur = 5'd1; min_cur = 6'd2;
        @(posedge clk);
        #1;
        btn_mode = 1'b1;
        exp_out(1, 2, 0, 0, 2'b01, cyc + DEB + 3);
        exp_out(1, 2, 0, 1, 2'b00, cyc + DEB + 3 + TOUT);
        repeat (8) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        repeat (80) @(posedge clk);

        // Collisions, then reset mid-edit
        ora_cur = 5'd3; min_cur = 6'd4;
        exp_out(3, 4, 0, 0, 2'b01); press(MODE, 8);
        exp_out(3, 4, 0, 0, 2'b10); press(MODE | UP, 8);
        press(UP | DN, 8);
        exp_out(3, 5, 0, 0, 2'b10); press(UP, 8);
        exp_out(0, 0, 0, 1, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);

        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting controller for the clock. It debounces the mode/up/down buttons and lets the user edit hours, then minutes. It drives the hour/minute set values and a one-cycle load strobe into the hours/minutes/seconds counter. It also pauses counting while editing.

## Interface

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles required before a debounced button level changes.
- REPEAT_DELAY, 25000000: cycles an up/down button must be held before auto-repeat starts.
- REPEAT_RATE, 5000000: cycles between auto-repeat steps after REPEAT_DELAY.
- TIMEOUT_CYCLES, 500000000: idle cycles in an edit state before the edit is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- btn_mode  in  1  raw asynchronous mode button, active-high.
- btn_up  in  1  raw asynchronous increment button, active-high.
- btn_down  in  1  raw asynchronous decrement button, active-high.
- ora_cur  in  5  current counter hour, 0..23.
- min_cur  in  6  current counter minute, 0..59.
- ora_setata  out  5  hour value to load, 0..23.
- min_setat  out  6  minute value to load, 0..59.
- load  out  1  one-cycle strobe; counter loads ora_setata/min_setat.
- run  out  1  counting allowed; the top level ANDs it with the 1 Hz tick to form the counter enable.
- edit_field  out  2  field under edit: 00 none, 01 hour, 10 minute (drives display blink).

## Operation

- Each button has a 2-FF synchronizer followed by a debouncer. The debounced level takes the synchronized value after that value has differed from the current level for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
- A press event is a one-cycle pulse on the rising edge of a debounced level. Releases generate nothing.
- Auto-repeat for up/down: while the debounced level stays high, an extra event fires REPEAT_DELAY cycles after the press event. Further events follow every REPEAT_RATE cycles. Release clears the repeat counter.
- FSM states: RUN, SET_H, SET_M, COMMIT.
  - RUN: on a mode event, capture ora_cur/min_cur into the edit registers and go to SET_H. A captured hour greater than 23 becomes 0; a captured minute greater than 59 becomes 0. Up/down events are ignored in RUN.
  - SET_H: an up event increments the hour (23 wraps to 0). A down event decrements it (0 wraps to 23). A mode event goes to SET_M.
  - SET_M: an up event increments the minute (59 wraps to 0). A down event decrements it (0 wraps to 59). A mode event goes to COMMIT.
  - COMMIT: lasts exactly one cycle with load=1, then returns to RUN.
- Timeout: a counter in SET_H/SET_M resets on any press event, including repeats. When it reaches TIMEOUT_CYCLES, the FSM returns to RUN without asserting load, and the counter time is untouched.
- Simultaneous events:
  - Mode together with up or down in the same cycle: mode wins and the step is dropped.
  - Up and down in the same cycle: both are ignored.
- Outputs:
  - ora_setata/min_setat continuously reflect the edit registers and are guaranteed valid whenever load=1.
  - run=0 in SET_H and SET_M; run=1 in RUN and COMMIT.
  - edit_field is 01 in SET_H, 10 in SET_M, and 00 otherwise.
- All arithmetic is on the 5-bit hour and 6-bit minute registers with explicit wrap compares. The registers never hold out-of-range values.

## Timing

- Reset values:
  - State RUN.
  - ora_setata=0, min_setat=0.
  - load=0, run=1, edit_field=00.
  - Synchronizers, debounced levels, and the debounce, repeat and timeout counters all 0.
- Reset applied mid-edit returns to RUN on the next edge with no load pulse.
- Press latency: a raw edge to a press event takes 2 synchronizer cycles plus DEB_CYCLES plus 1 cycle.
- The state and edit-register update occurs on the clock edge after the event cycle.
- load, run and edit_field are registered. Each changes in the cycle the FSM enters the corresponding state.
- load is high for exactly one cycle per commit and is never asserted twice without passing through SET_H and SET_M.
- The counter samples load on the same edge that ends COMMIT. The new time appears in the counter the following cycle.
- A press event arriving during COMMIT is dropped.

## Test plan

All scenarios use DEB_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT_CYCLES=64.

1. Full commit path: ora_cur=10, min_cur=30; press mode, up×2, mode, down×1, mode -> one load pulse with ora_setata=12, min_setat=29. run=0 during editing, and edit_field goes 01 then 10 then 00.
2. Wrap: enter edit with ora_cur=23, min_cur=0. In SET_H, up gives hour 0 and down gives 23. In SET_M, down gives 59 and up gives 0.
3. Bounce: toggle btn_up every 2 cycles for 20 cycles, then hold it high -> exactly one increment, occurring DEB_CYCLES+3 cycles after the final rising edge.
4. Auto-repeat: hold up in SET_M starting from minute 5 for 8+4×3 cycles after the press event -> minute 9 (1 press + 1 delayed + 2 repeats).
5. Timeout: enter SET_H, press nothing for 64 cycles -> return to RUN, no load, run=1, edit_field=00.
6. Collisions and reset: mode+up in the same cycle in SET_H -> moves to SET_M with the hour unchanged. up+down in the same cycle -> no change. rst asserted in SET_M -> RUN with all outputs at reset values and no load.
